// File: rtl/matrix_cfg_pkg.sv
// -----------------------------------------------------------------------------
// matrix_cfg_pkg
// Shared definitions for the pin-matrix configuration loader.
//   - default pin counts and config word width
//   - side codes carried in word[2:0]
//   - error codes reported on err_code
//   - loader state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package matrix_cfg_pkg;

    localparam int NUM_TB_DEF = 5;   // pins on the top and on the bottom edge
    localparam int NUM_LR_DEF = 4;   // pins on the left and on the right edge
    localparam int CFG_W_DEF  = 6;   // [2:0] side, [5:3] index
    localparam int SIDE_W     = 3;

    typedef enum logic [2:0] {
        SIDE_HIZ    = 3'd0,
        SIDE_TOP    = 3'd1,
        SIDE_RIGHT  = 3'd2,
        SIDE_BOTTOM = 3'd3,
        SIDE_LEFT   = 3'd4
    } side_e;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_SIDE  = 3'd1,
        ERR_INDEX = 3'd2,
        ERR_SELF  = 3'd3,
        ERR_CRC   = 3'd4
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/matrix_cfg_check.sv
// -----------------------------------------------------------------------------
// matrix_cfg_check
// Combinational legality check of one config word against the pin it is
// being loaded into.
// Ports:
//   word     in   CFG_W  config word: [2:0] side, [CFG_W-1:3] index
//   pin_idx  in   CNT_W  load position 0..2*NUM_TB+2*NUM_LR-1
//                        (top, bottom, left, right order)
//   err_code out  3      ERR_NONE / ERR_SIDE / ERR_INDEX / ERR_SELF
// -----------------------------------------------------------------------------
module matrix_cfg_check
    import matrix_cfg_pkg::*;
#(
    parameter int NUM_TB = NUM_TB_DEF,
    parameter int NUM_LR = NUM_LR_DEF,
    parameter int CFG_W  = CFG_W_DEF,
    parameter int CNT_W  = 5
) (
    input  logic [CFG_W-1:0] word,
    input  logic [CNT_W-1:0] pin_idx,
    output logic [2:0]       err_code
);

    localparam int IDX_W = CFG_W - SIDE_W;

    logic [SIDE_W-1:0] w_side;
    logic [IDX_W-1:0]  w_idx;
    int                pin_pos;
    int                w_num;
    side_e             pin_side;
    int                pin_num;
    logic              tb_side;
    logic              lr_side;

    assign w_side  = word[SIDE_W-1:0];
    assign w_idx   = word[CFG_W-1:SIDE_W];
    assign w_num   = int'(w_idx);
    assign pin_pos = int'(pin_idx);
    assign tb_side = (w_side == SIDE_TOP)   || (w_side == SIDE_BOTTOM);
    assign lr_side = (w_side == SIDE_RIGHT) || (w_side == SIDE_LEFT);

    // Map the load position back to the (side, index) of the pin being loaded.
    always_comb begin
        pin_side = SIDE_TOP;
        pin_num  = pin_pos;
        if (pin_pos < NUM_TB) begin
            pin_side = SIDE_TOP;
            pin_num  = pin_pos;
        end else if (pin_pos < 2*NUM_TB) begin
            pin_side = SIDE_BOTTOM;
            pin_num  = pin_pos - NUM_TB;
        end else if (pin_pos < 2*NUM_TB + NUM_LR) begin
            pin_side = SIDE_LEFT;
            pin_num  = pin_pos - 2*NUM_TB;
        end else begin
            pin_side = SIDE_RIGHT;
            pin_num  = pin_pos - 2*NUM_TB - NUM_LR;
        end
    end

    // Hi-Z (side 0) is always legal whatever the index bits hold.
    always_comb begin
        err_code = ERR_NONE;
        if (w_side > SIDE_LEFT) begin
            err_code = ERR_SIDE;
        end else if (w_side == SIDE_HIZ) begin
            err_code = ERR_NONE;
        end else if ((tb_side && (w_num >= NUM_TB)) || (lr_side && (w_num >= NUM_LR))) begin
            err_code = ERR_INDEX;
        end else if ((w_side == pin_side) && (w_num == pin_num)) begin
            err_code = ERR_SELF;
        end
    end

endmodule

// File: rtl/matrix_cfg_loader.sv
// -----------------------------------------------------------------------------
// matrix_cfg_loader
// Streams one config word per pin into a shadow array, checks each word as it
// arrives and, if the whole set is legal, copies it to the active outputs in a
// single cycle together with a done pulse. Any illegal word aborts the load,
// pulses err and leaves the active config untouched.
//
// Build option: define MATRIX_CFG_CRC_EN to require one extra word after the
// pin words, equal to the XOR of all of them (mismatch -> err code 4).
//
// Ports:
//   clk                        in   rising-edge clock
//   rst                        in   synchronous active-high reset
//   start                      in   begin a load (IDLE only)
//   in_valid / in_ready        in/out  word handshake
//   in_word                    in   CFG_W config word
//   dtop_flat, dbottom_flat    out  NUM_TB*CFG_W active config, pin i at [i*CFG_W +: CFG_W]
//   dleft_flat, dright_flat    out  NUM_LR*CFG_W active config, same packing
//   busy                       out  not IDLE
//   done                       out  one-cycle pulse on commit
//   err                        out  one-cycle pulse on abort
//   err_code                   out  3-bit reason, held until the next start
// -----------------------------------------------------------------------------
module matrix_cfg_loader
    import matrix_cfg_pkg::*;
#(
    parameter int NUM_TB = NUM_TB_DEF,
    parameter int NUM_LR = NUM_LR_DEF,
    parameter int CFG_W  = CFG_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CFG_W-1:0]        in_word,
    output logic [NUM_TB*CFG_W-1:0] dtop_flat,
    output logic [NUM_TB*CFG_W-1:0] dbottom_flat,
    output logic [NUM_LR*CFG_W-1:0] dleft_flat,
    output logic [NUM_LR*CFG_W-1:0] dright_flat,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2:0]              err_code
);

    localparam int NUM_WORDS = 2*NUM_TB + 2*NUM_LR;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam int ARR_W     = NUM_WORDS * CFG_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [ARR_W-1:0]  shadow_q,   shadow_d;
    logic [ARR_W-1:0]  active_q,   active_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [2:0]        err_code_q, err_code_d;
`ifdef MATRIX_CFG_CRC_EN
    logic [CFG_W-1:0]  crc_q,      crc_d;
`endif

    logic       xfer;
    logic [2:0] chk_code;

    assign xfer = in_valid && in_ready_q;

    matrix_cfg_check #(
        .NUM_TB (NUM_TB),
        .NUM_LR (NUM_LR),
        .CFG_W  (CFG_W),
        .CNT_W  (CNT_W)
    ) u_check (
        .word     (in_word),
        .pin_idx  (cnt_q),
        .err_code (chk_code)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
`ifdef MATRIX_CFG_CRC_EN
        crc_d      = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // err_q marks the cycle an abort is reported; a start there
                // belongs to the aborted load and is dropped.
                if (start && !err_q) begin
                    state_d    = ST_LOAD;
                    cnt_d      = '0;
                    err_code_d = ERR_NONE;
`ifdef MATRIX_CFG_CRC_EN
                    crc_d      = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (chk_code != ERR_NONE) begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = chk_code;
                        shadow_d   = '0;
                    end else begin
                        shadow_d[int'(cnt_q)*CFG_W +: CFG_W] = in_word;
                        cnt_d = cnt_q + CNT_W'(1);
`ifdef MATRIX_CFG_CRC_EN
                        crc_d = crc_q ^ in_word;
                        if (cnt_q == LAST_IDX) begin
                            state_d = ST_CHECK;
                        end
`else
                        // Last pin word: publish the whole set together with done.
                        if (cnt_q == LAST_IDX) begin
                            state_d  = ST_COMMIT;
                            done_d   = 1'b1;
                            active_d = shadow_d;
                        end
`endif
                    end
                end
            end
`ifdef MATRIX_CFG_CRC_EN
            ST_CHECK: begin
                if (xfer) begin
                    if (in_word == crc_q) begin
                        state_d  = ST_COMMIT;
                        done_d   = 1'b1;
                        active_d = shadow_q;
                    end else begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_CRC;
                        shadow_d   = '0;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
`ifdef MATRIX_CFG_CRC_EN
            crc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
`ifdef MATRIX_CFG_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign dtop_flat    = active_q[0 +: NUM_TB*CFG_W];
    assign dbottom_flat = active_q[NUM_TB*CFG_W +: NUM_TB*CFG_W];
    assign dleft_flat   = active_q[2*NUM_TB*CFG_W +: NUM_LR*CFG_W];
    assign dright_flat  = active_q[(2*NUM_TB+NUM_LR)*CFG_W +: NUM_LR*CFG_W];

endmodule

// File: doc/matrix_cfg_loader.md
MATRIX_CFG_LOADER -- requirements
Module: matrix_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_TB, default 5, meaning top/bottom pin count.
REQ-002 SHALL have parameter NUM_LR, default 4, meaning left/right pin count.
REQ-003 SHALL have parameter CFG_W, default 6, meaning config word width: [2:0] side, [5:3] index.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  begin a new load; honoured only in IDLE.
REQ-007 SHALL have port in_valid  input  1  in_word is valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_word this cycle.
REQ-009 SHALL have port in_word  input  CFG_W  one pin config word.
REQ-010 SHALL have ports dtop_flat, dbottom_flat  output  NUM_TB*CFG_W  active top/bottom config, pin i at [i*CFG_W +: CFG_W].
REQ-011 SHALL have ports dleft_flat, dright_flat  output  NUM_LR*CFG_W  active left/right config, same packing.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on successful commit.
REQ-014 SHALL have port err  output  1  one-cycle pulse on aborted load.
REQ-015 SHALL have port err_code  output  3  0 none, 1 bad side, 2 index range, 3 self-route, 4 checksum; held until next start.

Function
REQ-016 SHALL implement states IDLE, LOAD, CHECK, COMMIT; IDLE->LOAD on start; LOAD->CHECK (or COMMIT without CRC) after last word; CHECK->COMMIT on checksum match; COMMIT->IDLE after one cycle.
REQ-017 SHALL transfer a word only when in_valid && in_ready; in_ready SHALL be high only in LOAD and CHECK.
REQ-018 SHALL accept 2*NUM_TB+2*NUM_LR words in fixed order: top0..top4, bottom0..bottom4, left0..left3, right0..right3, tracked by a word counter reset to 0 on start.
REQ-019 SHALL write accepted words into a shadow array only; active outputs SHALL change only in COMMIT, all pins in the same cycle as done.
REQ-020 SHALL validate each word on acceptance: side >4 -> code 1; side 1/3 with index >= NUM_TB or side 2/4 with index >= NUM_LR -> code 2; side/index naming the pin being loaded -> code 3; side 0 SHALL always be legal with index ignored.
REQ-021 SHALL, on any error, pulse err the cycle after the offending word, discard the shadow, leave active outputs unchanged, and return to IDLE.
REQ-022 SHALL assert done exactly one cycle after the final accepted word (or checksum word); the latency from start to done with back-to-back valid words SHALL be 20 cycles, or 21 with CRC.
REQ-023 SHALL allow in_valid gaps of any length without state loss.
REQ-024 SHALL ignore start while busy, including start coincident with done or err.

Reset
REQ-025 SHALL, on rst, set state IDLE, counter 0, shadow and all active outputs to zero (all pins hi-Z), and busy, done, err and err_code to 0.
REQ-026 SHALL let rst mid-load override everything in that cycle; no partial config SHALL reach the outputs.

Configuration
REQ-027 SHALL, with macro MATRIX_CFG_CRC_EN defined, require one extra word in CHECK equal to the XOR of all loaded words; a mismatch SHALL give err with code 4.
REQ-028 SHALL, without MATRIX_CFG_CRC_EN, omit state CHECK and go LOAD->COMMIT; code 4 SHALL never occur.

Structure
REQ-029 SHALL take NUM_TB/NUM_LR defaults, CFG_W, the side codes (0 hi-Z, 1 top, 2 right, 3 bottom, 4 left), err codes and the state encoding from shared package matrix_cfg_pkg.
REQ-030 SHALL place the per-word legality check in combinational sub-module matrix_cfg_check (inputs word and pin position; outputs err_code).

Verification
REQ-031 SHALL cover the all-zero load: start, then 18 words of 6'b000000 -> done at cycle 20, all outputs 0, err 0.
REQ-032 SHALL cover a route load: top0 = 6'b001010 (right1), right1 = 6'b000001 (top0), others 0 -> dtop_flat[5:0] = 6'b001010 and dright_flat[11:6] = 6'b000001 after done.
REQ-033 SHALL cover bad index: word 10 (left0) = 6'b100010 (right4) -> err, err_code 2, outputs keep the previous config.
REQ-034 SHALL cover self-route and bad side: word 0 = 6'b000001 -> err, code 3; separately word 3 = 6'b000111 -> err, code 1.
REQ-035 SHALL cover reset mid-load: rst after 7 words -> outputs 0, busy 0; a following full load with in_valid toggling every other cycle -> done, correct outputs.
REQ-036 SHALL cover the checksum (MATRIX_CFG_CRC_EN): correct XOR word -> done; XOR^6'b000001 -> err, code 4.
